sccomp_run_ctrl: RTL



---
 rtl/sccomp_run_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sccomp_run_ctrl.sv
// Run/debug sequencer for the single-cycle core: gates execution per instruction
// (run-to-breakpoint, single step, host halt, global limit) and streams out the register file.
module sccomp_run_ctrl #(
  parameter int unsigned STEP_LIMIT = 1000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_arg,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic             halted,
  output logic [1:0]       stop_cause,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_DSEL, S_DOUT} state_t;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  localparam logic [1:0] CAUSE_STEP  = 2'b00;
  localparam logic [1:0] CAUSE_BP    = 2'b01;
  localparam logic [1:0] CAUSE_LIMIT = 2'b10;
  localparam logic [1:0] CAUSE_HOST  = 2'b11;

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STEP_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [4:0]       IDX_LAST = 5'd31;

  state_t            state_q, state_d;
  logic [31:0]       bp_q, bp_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        sel_q, sel_d;
  logic [4:0]        didx_q, didx_d;
  logic [31:0]       ddata_q, ddata_d;

  logic bp_hit, lim_hit, halt_req;

  // Stop conditions are combinational so cpu_en drops in the very cycle they appear.
  assign bp_hit   = (pc == bp_q) && !first_q;
  assign lim_hit  = (cnt_q >= LIMIT);
  assign halt_req = cmd_valid && (cmd_op == OP_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bp_q    <= '0;
      first_q <= 1'b0;
      cnt_q   <= '0;
      cause_q <= CAUSE_STEP;
      idx_q   <= '0;
      sel_q   <= '0;
      didx_q  <= '0;
      ddata_q <= '0;
    end else begin
      state_q <= state_d;
      bp_q    <= bp_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      didx_q  <= didx_d;
      ddata_q <= ddata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bp_d    = bp_q;
    first_d = 1'b0;
    cause_d = cause_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    didx_d  = didx_q;
    ddata_d = ddata_q;
    cnt_d   = cpu_en ? (cnt_q + CNT_ONE) : cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_RUN: begin
              bp_d    = cmd_arg;
              first_d = 1'b1;
              state_d = S_RUN;
            end
            OP_STEP: state_d = S_STEP;
            OP_DUMP: begin
              idx_d   = '0;
              state_d = S_DSEL;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (bp_hit) begin
          cause_d = CAUSE_BP;
          state_d = S_IDLE;
        end else if (lim_hit) begin
          cause_d = CAUSE_LIMIT;
          state_d = S_IDLE;
        end else if (halt_req) begin
          cause_d = CAUSE_HOST;
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        cause_d = lim_hit ? CAUSE_LIMIT : CAUSE_STEP;
        state_d = S_IDLE;
      end
      S_DSEL: begin
        sel_d   = idx_q;
        ddata_d = reg_data;
        didx_d  = idx_q;
        state_d = S_DOUT;
      end
      S_DOUT: begin
        if (dump_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_DSEL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    cpu_en     = 1'b0;
    dump_valid = 1'b0;
    halted     = 1'b1;
    reg_sel    = sel_q;
    unique case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_RUN: begin
        cmd_ready = (cmd_op == OP_HALT);
        cpu_en    = !bp_hit && !lim_hit && !halt_req;
        halted    = 1'b0;
      end
      S_STEP: begin
        cpu_en = !lim_hit;
        halted = 1'b0;
      end
      S_DSEL: reg_sel = idx_q;
      S_DOUT: dump_valid = 1'b1;
      default: ;
    endcase
  end

  assign dump_idx   = didx_q;
  assign dump_data  = ddata_q;
  assign stop_cause = cause_q;
  assign step_cnt   = cnt_q;

endmodule
